// File: rtl/fsm_pkg.sv
// Shared types and default constants for the serial frame decoder, its interface and bench.
package fsm_pkg;

  localparam int             SYNC_W_DEF      = 8;
  localparam logic [7:0]     SYNC_WORD_DEF   = 8'hA5;
  localparam int             PAYLOAD_W_DEF   = 8;
  localparam int             INIT_CYCLES_DEF = 4;
  localparam int             CNT_W_DEF       = 8;

  localparam logic [1:0]     ST_INIT   = 2'd0;
  localparam logic [1:0]     ST_DECODE = 2'd1;
  localparam logic [1:0]     ST_IDLE   = 2'd2;

  typedef enum logic [1:0] {
    INIT   = ST_INIT,
    DECODE = ST_DECODE,
    IDLE   = ST_IDLE
  } fsmstate_e;

  // Self-loops plus the three forward arcs; reset-driven entry to INIT is outside this check.
  function automatic logic legal_transition(input logic [1:0] from_st, input logic [1:0] to_st);
    logic ok;
    ok = (from_st == to_st)
      || (from_st == ST_INIT   && to_st == ST_IDLE)
      || (from_st == ST_IDLE   && to_st == ST_DECODE)
      || (from_st == ST_DECODE && to_st == ST_IDLE);
    return ok;
  endfunction

endpackage

// File: rtl/fsmifc.sv
// Decoder-side bundle: serial input in, FSM state and decoded frame results out.
interface fsmifc #(
  parameter int PAYLOAD_W = 8,
  parameter int CNT_W     = 8
);
  import fsm_pkg::*;

  logic                 pi;
  logic                 po;
  fsmstate_e            state;
  logic [PAYLOAD_W-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic [CNT_W-1:0]     frame_cnt;

  modport cb_dut (
    input  pi,
    output po, state, data_out, data_valid, parity_err, frame_cnt
  );

  modport master (
    input  pi,
    output po, state, data_out, data_valid, parity_err, frame_cnt
  );

  modport slave (
    output pi,
    input  po, state, data_out, data_valid, parity_err, frame_cnt
  );

endinterface

// File: rtl/fsm_sync_detect.sv
// Sync-word hunter: shift register with enable/clear and a combinational match on the
// window formed by the stored history plus the bit currently on the line.
module fsm_sync_detect #(
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic bit_i,
  output logic match_o
);

  if (SYNC_W < 2) begin : g_bad_width
    $error("fsm_sync_detect: SYNC_W must be at least 2");
  end
  if (SYNC_WORD == '0) begin : g_bad_word
    $error("fsm_sync_detect: SYNC_WORD must not be all-zero");
  end

  // Only SYNC_W-1 history bits are kept: the oldest bit of a full-width shifter never
  // reaches the match window.
  logic [SYNC_W-2:0] sr_q, sr_d;
  logic [SYNC_W-1:0] window;

  assign window  = {sr_q, bit_i};
  assign match_o = (window == SYNC_WORD);

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      sr_d = window[SYNC_W-2:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/fsm_frame_decoder.sv
// Serial frame decoder: INIT settle, hunt for the sync word, shift in an MSB-first payload,
// check even parity and present the byte with valid/good-frame pulses and a saturating count.
module fsm_frame_decoder
  import fsm_pkg::*;
#(
  parameter int                SYNC_W      = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(SYNC_WORD_DEF),
  parameter int                PAYLOAD_W   = PAYLOAD_W_DEF,
  parameter int                INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int                CNT_W       = CNT_W_DEF
) (
  input  logic  clk,
  input  logic  reset,
  fsmifc.cb_dut bus
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int BIT_W  = $clog2(PAYLOAD_W + 1);

  logic [1:0]           state_q, state_d;
  logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic                 po_q, po_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 sync_en, sync_clr, sync_match;
  logic [PAYLOAD_W-1:0] payload_shift;
  logic                 parity_bad;

  fsm_sync_detect #(
    .SYNC_W    (SYNC_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .en_i    (sync_en),
    .clr_i   (sync_clr),
    .bit_i   (bus.pi),
    .match_o (sync_match)
  );

  if (PAYLOAD_W > 1) begin : g_shift_multi
    assign payload_shift = {payload_q[PAYLOAD_W-2:0], bus.pi};
  end else begin : g_shift_single
    assign payload_shift = bus.pi;
  end

  // Parity is judged over the full payload plus the bit arriving on this edge.
  assign parity_bad = ^{payload_q, bus.pi};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned;
    // a missing default here would infer a latch.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    payload_d  = payload_q;
    data_d     = data_q;
    po_d       = 1'b0;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    cnt_d      = cnt_q;
    sync_en    = 1'b0;
    sync_clr   = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        sync_en = 1'b1;
        if (sync_match) begin
          sync_clr  = 1'b1;
          state_d   = ST_DECODE;
          bit_cnt_d = '0;
        end
      end

      ST_DECODE: begin
        if (bit_cnt_q == BIT_W'(PAYLOAD_W)) begin
          state_d = ST_IDLE;
          data_d  = payload_q;
          valid_d = 1'b1;
          perr_d  = parity_bad;
          po_d    = ~parity_bad;
          if (!parity_bad && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          payload_d = payload_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      bit_cnt_q  <= '0;
      payload_q  <= '0;
      data_q     <= '0;
      po_q       <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      payload_q  <= payload_d;
      data_q     <= data_d;
      po_q       <= po_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.state      = fsmstate_e'(state_q);
  assign bus.po         = po_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_cnt  = cnt_q;

  a_legal_transition: assert property (
    @(posedge clk) disable iff (reset) legal_transition(state_q, state_d)
  );

endmodule

// File: tb/tb_fsm_frame_decoder.sv
// Directed bench for fsm_frame_decoder: reset/INIT timing, good and bad frames, overlapping
// sync prefix, reset mid-frame, and counter saturation on a narrow-counter instance.
module tb_fsm_frame_decoder;
  import fsm_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fsmifc #(.PAYLOAD_W(8), .CNT_W(8)) bus_a ();
  fsmifc #(.PAYLOAD_W(8), .CNT_W(2)) bus_b ();

  fsm_frame_decoder #(
    .SYNC_W(8), .SYNC_WORD(8'hA5), .PAYLOAD_W(8), .INIT_CYCLES(4), .CNT_W(8)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  fsm_frame_decoder #(
    .SYNC_W(8), .SYNC_WORD(8'hA5), .PAYLOAD_W(8), .INIT_CYCLES(4), .CNT_W(2)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  // Monitor on the narrow-counter instance: po pulses and observed state arcs.
  int        po_b_pulses = 0;
  int        arc_init_idle = 0;
  int        arc_idle_dec  = 0;
  int        arc_dec_idle  = 0;
  fsmstate_e prev_b = INIT;

  always @(negedge clk) begin
    if (!rst_b) begin
      if (bus_b.po) po_b_pulses++;
      if (prev_b == INIT   && bus_b.state == IDLE)   arc_init_idle++;
      if (prev_b == IDLE   && bus_b.state == DECODE) arc_idle_dec++;
      if (prev_b == DECODE && bus_b.state == IDLE)   arc_dec_idle++;
    end
    prev_b = bus_b.state;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus_a.pi = b;
    bus_b.pi = b;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] payload, input logic parity);
    send_byte(8'hA5);
    send_byte(payload);
    send_bit(parity);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] stream;
    logic [7:0]  payloads [5];
    logic [1:0]  cnt_exp  [5];
    int          entries;
    int          first_idx;
    fsmstate_e   prev;

    // 1: reset values and INIT duration
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.pi = 1'b0;
    bus_b.pi = 1'b0;
    repeat (3) tick();
    check("rst_state",  bus_a.state,      INIT);
    check("rst_po",     bus_a.po,         1'b0);
    check("rst_valid",  bus_a.data_valid, 1'b0);
    check("rst_perr",   bus_a.parity_err, 1'b0);
    check("rst_data",   bus_a.data_out,   8'h00);
    check("rst_cnt",    bus_a.frame_cnt,  8'd0);
    rst_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("init_cyc%0d", k), bus_a.state, (k <= 4) ? INIT : IDLE);
    end
    check("init_valid", bus_a.data_valid, 1'b0);

    // 2: good frame A5 / 3C / parity 0
    send_byte(8'hA5);
    check("t2_enter_decode", bus_a.state, DECODE);
    send_byte(8'h3C);
    check("t2_still_decode", bus_a.state, DECODE);
    send_bit(1'b0);
    check("t2_state", bus_a.state,      IDLE);
    check("t2_valid", bus_a.data_valid, 1'b1);
    check("t2_po",    bus_a.po,         1'b1);
    check("t2_data",  bus_a.data_out,   8'h3C);
    check("t2_perr",  bus_a.parity_err, 1'b0);
    check("t2_cnt",   bus_a.frame_cnt,  8'd1);
    send_bit(1'b0);
    check("t2_valid_drop", bus_a.data_valid, 1'b0);
    check("t2_po_drop",    bus_a.po,         1'b0);
    check("t2_data_hold",  bus_a.data_out,   8'h3C);

    // 3: same payload, bad parity
    send_frame(8'h3C, 1'b1);
    check("t3_valid", bus_a.data_valid, 1'b1);
    check("t3_perr",  bus_a.parity_err, 1'b1);
    check("t3_po",    bus_a.po,         1'b0);
    check("t3_data",  bus_a.data_out,   8'h3C);
    check("t3_cnt",   bus_a.frame_cnt,  8'd1);
    send_bit(1'b0);

    // 4: prefix 1010 then A5 -> exactly one DECODE entry, on the last bit
    stream    = 12'hAA5;
    entries   = 0;
    first_idx = -1;
    prev      = bus_a.state;
    for (int i = 11; i >= 0; i--) begin
      send_bit(stream[i]);
      if (prev != DECODE && bus_a.state == DECODE) begin
        entries++;
        if (first_idx < 0) first_idx = i;
      end
      prev = bus_a.state;
    end
    check("t4_entries",   entries,     1);
    check("t4_entry_bit", first_idx,   0);
    check("t4_state",     bus_a.state, DECODE);
    send_byte(8'h00);
    send_bit(1'b0);
    check("t4_po",   bus_a.po,        1'b1);
    check("t4_data", bus_a.data_out,  8'h00);
    check("t4_cnt",  bus_a.frame_cnt, 8'd2);
    send_bit(1'b0);

    // 5: reset at payload bit 4 discards the frame
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("t5_mid_decode", bus_a.state, DECODE);
    #1 rst_a = 1'b1;
    #1;
    check("t5_rst_state", bus_a.state,      INIT);
    check("t5_rst_valid", bus_a.data_valid, 1'b0);
    check("t5_rst_po",    bus_a.po,         1'b0);
    check("t5_rst_cnt",   bus_a.frame_cnt,  8'd0);
    bus_a.pi = 1'b0;
    bus_b.pi = 1'b0;
    repeat (2) tick();
    rst_a = 1'b0;
    repeat (4) tick();
    check("t5_init_hold", bus_a.state, INIT);
    tick();
    check("t5_idle",  bus_a.state,      IDLE);
    check("t5_quiet", bus_a.data_valid, 1'b0);
    send_frame(8'h81, 1'b0);
    check("t5_valid", bus_a.data_valid, 1'b1);
    check("t5_po",    bus_a.po,         1'b1);
    check("t5_data",  bus_a.data_out,   8'h81);
    check("t5_cnt",   bus_a.frame_cnt,  8'd1);
    send_bit(1'b0);

    // 6: narrow counter saturates over five back-to-back good frames
    payloads = '{8'h3C, 8'h00, 8'h81, 8'hFF, 8'h5A};
    cnt_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_b = 1'b0;
    repeat (5) tick();
    check("t6_idle", bus_b.state, IDLE);
    for (int f = 0; f < 5; f++) begin
      send_frame(payloads[f], 1'b0);
      check($sformatf("t6_po_f%0d",  f), bus_b.po,        1'b1);
      check($sformatf("t6_cnt_f%0d", f), bus_b.frame_cnt, cnt_exp[f]);
    end
    send_bit(1'b0);
    check("t6_data_last",  bus_b.data_out,  8'h5A);
    check("t6_po_pulses",  po_b_pulses,     5);
    check("t6_arc_init",   arc_init_idle,   1);
    check("t6_arc_idle",   arc_idle_dec,    5);
    check("t6_arc_decode", arc_dec_idle,    5);
    check("t6_cnt_wide",   bus_a.frame_cnt, 8'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
